// File: rtl/seq_det_pkg.sv
// Shared widths, types and helpers for the multi-channel sequence detector.
package seq_det_pkg;

  localparam int unsigned N_CHAN = 4;
  localparam int unsigned MAXLEN = 8;
  localparam int unsigned CHAN_W = $clog2(N_CHAN);
  localparam int unsigned LEN_W  = $clog2(MAXLEN + 1);

  typedef logic [MAXLEN-1:0] hist_t;
  typedef logic [CHAN_W-1:0] chan_t;

  // Word with the low len bits set; callers slice it to their history width.
  function automatic logic [31:0] len_mask(input int unsigned len);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N requests, search starts after the last grant.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         grant_c,
  output logic [$clog2(N)-1:0] idx_c,
  output logic                 any_c
);

  localparam int unsigned W = $clog2(N);

  logic [W-1:0] last_q;
  logic [W-1:0] last_d;
  logic [W-1:0] cand;

  // Reset to the highest index so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) last_q <= W'(N - 1);
    else     last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (any_c) last_d = idx_c;
  end

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = W'((32'(last_q) + i) % N);
      if (en && !any_c && req[cand]) begin
        grant_c[cand] = 1'b1;
        idx_c         = cand;
        any_c         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// One shared pattern comparator time-multiplexed over N serial bit streams.
module seq_detect_scheduler #(
  parameter int unsigned       N_CHAN      = seq_det_pkg::N_CHAN,
  parameter int unsigned       MAXLEN      = seq_det_pkg::MAXLEN,
  parameter logic [MAXLEN-1:0] RST_PATTERN = MAXLEN'(8'b0000_1011),
  parameter int unsigned       RST_LEN     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CHAN-1:0]             in_valid,
  input  logic [N_CHAN-1:0]             in_bit,
  output logic [N_CHAN-1:0]             in_ready,
  input  logic                          cfg_we,
  input  logic [MAXLEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAXLEN+1)-1:0]   cfg_len,
  output logic                          match_valid,
  output logic [$clog2(N_CHAN)-1:0]     match_chan,
  output logic                          busy
);

  import seq_det_pkg::*;

  localparam int unsigned CH_W = $clog2(N_CHAN);
  localparam int unsigned LN_W = $clog2(MAXLEN + 1);

  logic [MAXLEN-1:0] pattern_q;
  logic [LN_W-1:0]   len_q;
  logic [MAXLEN-1:0] hist_q [N_CHAN];
  logic [LN_W-1:0]   cnt_q  [N_CHAN];

  logic              grant_en;
  logic              xfer;
  logic [CH_W-1:0]   gidx;
  logic [MAXLEN-1:0] new_hist;
  logic [MAXLEN-1:0] mask;
  logic [LN_W-1:0]   new_cnt;
  logic [LN_W-1:0]   cfg_len_clamped;
  logic              hit;

  // Config writes and reset steal the cycle, so no grant is offered.
  assign grant_en = !rst && !cfg_we;

  rr_arbiter #(.N(N_CHAN)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .en      (grant_en),
    .grant_c (in_ready),
    .idx_c   (gidx),
    .any_c   (xfer)
  );

  // Shared comparator works on the granted channel's post-shift history.
  always_comb begin
    new_hist = {hist_q[gidx][MAXLEN-2:0], in_bit[gidx]};
    new_cnt  = (cnt_q[gidx] >= LN_W'(MAXLEN)) ? cnt_q[gidx] : cnt_q[gidx] + LN_W'(1);
    mask     = MAXLEN'(len_mask(32'(len_q)));
    hit      = (len_q != '0) && (((new_hist ^ pattern_q) & mask) == '0) && (new_cnt >= len_q);
    cfg_len_clamped = (cfg_len > LN_W'(MAXLEN)) ? LN_W'(MAXLEN) : cfg_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q   <= RST_PATTERN;
      len_q       <= LN_W'(RST_LEN);
      match_valid <= 1'b0;
      match_chan  <= '0;
      for (int unsigned c = 0; c < N_CHAN; c++) begin
        hist_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      match_valid <= xfer && hit;
      if (xfer && hit) match_chan <= gidx;
      if (cfg_we) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len_clamped;
        for (int unsigned c = 0; c < N_CHAN; c++) begin
          hist_q[c] <= '0;
          cnt_q[c]  <= '0;
        end
      end else if (xfer) begin
        hist_q[gidx] <= new_hist;
        cnt_q[gidx]  <= new_cnt;
      end
    end
  end

  assign busy = (|in_valid) || match_valid;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: queue-based reference model plus directed and random stimulus.
module tb_seq_detect_scheduler;

  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_bit;
  logic [3:0] in_ready;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       match_valid;
  logic [1:0] match_chan;
  logic       busy;

  seq_detect_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_ready    (in_ready),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .match_valid (match_valid),
    .match_chan  (match_chan),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int   total  = 0;
  int   passed = 0;
  bit   known  = 0;
  int   m_last;
  int   m_len;
  logic [7:0] m_pat;
  bit   seen [NC][$];
  bit   exp_mv;
  int   exp_mc;
  int   mcount;
  int   last_match_step;
  int   step_no;
  logic [3:0] obs_ready;
  logic       obs_mv;
  logic [1:0] obs_mc;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (step %0d)", name, act, exp, step_no);
  endtask

  // Drive one cycle, compare against the model, then advance the model past the posedge.
  task automatic step(input logic [3:0] v, input logic [3:0] b, input logic we,
                      input logic [7:0] cp, input logic [3:0] cl, input logic r);
    int g;
    int c;
    int n;
    bit ok;
    in_valid = v; in_bit = b; cfg_we = we; cfg_pattern = cp; cfg_len = cl; rst = r;
    #1;
    g = -1;
    if (!r && !we) begin
      for (int i = 1; i <= NC; i++) begin
        c = (m_last + i) % NC;
        if (g < 0 && v[c]) g = c;
      end
    end
    obs_ready = in_ready;
    obs_mv    = match_valid;
    obs_mc    = match_chan;
    if (known) begin
      check("in_ready", int'(in_ready), (g >= 0) ? (1 << g) : 0);
      check("match_valid", int'(match_valid), int'(exp_mv));
      if (exp_mv) check("match_chan", int'(match_chan), exp_mc);
      check("busy", int'(busy), int'((|v) || exp_mv));
    end
    if (match_valid) begin
      mcount++;
      last_match_step = step_no;
    end
    ok = 0;
    if (r) begin
      m_pat = 8'b0000_1011; m_len = 4; m_last = NC - 1;
      for (int k = 0; k < NC; k++) seen[k].delete();
      known = 1;
    end else if (we) begin
      m_pat = cp;
      m_len = (cl > 4'd8) ? 8 : int'(cl);
      for (int k = 0; k < NC; k++) seen[k].delete();
    end else if (g >= 0) begin
      seen[g].push_back(b[g]);
      m_last = g;
      n = seen[g].size();
      if (m_len > 0 && n >= m_len) begin
        ok = 1;
        for (int k = 0; k < m_len; k++) if (seen[g][n-1-k] != m_pat[k]) ok = 0;
      end
      if (ok) exp_mc = g;
    end
    exp_mv = ok;
    step_no++;
    @(negedge clk);
  endtask

  task automatic send(input int ch, input bit bv);
    step(4'(1 << ch), bv ? 4'(1 << ch) : 4'h0, 1'b0, 8'h00, 4'h0, 1'b0);
  endtask

  task automatic idle();
    step(4'h0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(4'h0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b1);
  endtask

  bit s12 [12] = '{1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1};

  initial begin
    int base;
    logic [3:0] seqb;
    logic [3:0] bv;
    logic       r;
    logic       we;
    rst = 1'b1; in_valid = '0; in_bit = '0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    step_no = 0; exp_mv = 0; exp_mc = 0; m_last = NC - 1; m_len = 4; m_pat = 8'h0B;
    mcount = 0; last_match_step = -1;
    @(negedge clk);

    // Reset state and immediate grant
    do_reset(); do_reset();
    idle();
    check("rst_ready_zero", int'(obs_ready), 0);
    check("rst_busy_zero", int'(busy), 0);
    check("rst_match_chan", int'(match_chan), 0);
    mcount = 0;
    send(0, 1);
    check("first_grant_ch0", int'(obs_ready), 1);
    send(0, 0); send(0, 1); send(0, 1);
    idle();
    check("a_match1_valid", int'(obs_mv), 1);
    check("a_match1_chan", int'(obs_mc), 0);
    send(0, 0); send(0, 1); send(0, 1);
    idle();
    check("a_overlap_valid", int'(obs_mv), 1);
    check("a_match_count", mcount, 2);

    // All channels valid: strict rotation, one match on ch2
    do_reset();
    mcount = 0; seqb = 4'b1101; base = step_no;
    for (int i = 0; i < 16; i++) begin
      bv = (i % 4 == 2) ? (seqb[i/4] ? 4'b0100 : 4'b0000) : 4'b0000;
      step(4'hF, bv, 1'b0, 8'h00, 4'h0, 1'b0);
      check("b_rotation", int'(obs_ready), 1 << (i % 4));
    end
    check("b_match_count", mcount, 1);
    check("b_match_cycle", last_match_step - base, 15);
    check("b_match_chan", int'(obs_mc), 2);

    // Reconfiguration clears history and blocks the grant
    do_reset();
    mcount = 0;
    send(1, 1); send(1, 0); send(1, 1);
    step(4'b0010, 4'b0010, 1'b1, 8'b0000_0110, 4'd3, 1'b0);
    check("c_cfg_no_grant", int'(obs_ready), 0);
    send(1, 1); send(1, 1); send(1, 0);
    idle();
    check("c_match_after_cfg", int'(obs_mv), 1);
    check("c_match_count", mcount, 1);

    // Reset mid-stream clears history and restores channel 0 priority
    do_reset();
    mcount = 0;
    send(3, 1); send(3, 0); send(3, 1);
    do_reset();
    step(4'b1001, 4'b0000, 1'b0, 8'h00, 4'h0, 1'b0);
    check("d_priority_ch0", int'(obs_ready), 1);
    send(3, 1);
    idle();
    check("d_match_count", mcount, 0);

    // len=0 disables matching; len=12 clamps to 8
    step(4'h0, 4'h0, 1'b1, 8'b0000_1011, 4'd0, 1'b0);
    mcount = 0;
    for (int i = 0; i < 12; i++) send(0, (i % 4 == 1) ? 1'b0 : 1'b1);
    idle();
    check("e_len0_no_match", mcount, 0);
    step(4'h0, 4'h0, 1'b1, 8'b0000_1011, 4'd12, 1'b0);
    mcount = 0;
    for (int i = 0; i < 12; i++) send(0, s12[i]);
    idle();
    check("e_clamp_match_count", mcount, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      we = !r && ($urandom_range(0, 39) == 0);
      step(4'($urandom), 4'($urandom), we, 8'($urandom),
           ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 12)) : 4'($urandom_range(1, 3)), r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
